// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display controller.
package seg_pkg;

  // Active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0..F, dp off.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Bits needed to hold a slot counter that runs 0..div-1.
  function automatic int cnt_width(input int div);
    int w;
    w = 1;
    while (((1 << w) < div) && (w < 31)) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-low seven-segment pattern (dp handled by the caller).
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble][6:0];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed common-anode seven-segment controller: double-buffered digit data,
// frame-aligned updates, leading-zero blanking, PWM brightness and dead time.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    load,
  output logic                    pending,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   LEDSEL,
  output logic [7:0]              LEDOUT
);

  localparam int CW = cnt_width(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = CW + BRIGHT_BITS + 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   cnt_tc;
  logic                   frame_end;

  logic [DW-1:0]          sh_data, act_data;
  logic [NUM_DIGITS-1:0]  sh_dp, act_dp;
  logic                   sh_blz, act_blz;
  logic [BRIGHT_BITS-1:0] sh_bright, act_bright;
  logic                   act_valid;

  assign cnt_tc    = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = cnt_tc && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_tc) begin
      cnt <= '0;
      idx <= frame_end ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load on the transfer edge still lets the older shadow through first.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data    <= '0;
      sh_dp      <= '0;
      sh_blz     <= 1'b0;
      sh_bright  <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blz    <= 1'b0;
      act_bright <= '0;
      act_valid  <= 1'b0;
      pending    <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        act_data   <= sh_data;
        act_dp     <= sh_dp;
        act_blz    <= sh_blz;
        act_bright <= sh_bright;
        act_valid  <= 1'b1;
      end
      if (load) begin
        sh_data   <= data_in;
        sh_dp     <= dp_in;
        sh_blz    <= blank_lz;
        sh_bright <= brightness;
        pending   <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  logic [3:0]            cur_nib;
  logic [6:0]            cur_seg;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] hi_zero;
  logic [NUM_DIGITS-1:0] anode;
  logic [PW-1:0]         duty_prod;
  logic [PW-1:0]         on_time;
  logic                  lit;
  logic                  blanked;
  logic [NUM_DIGITS-1:0] sel_d;
  logic [7:0]            out_d;

  assign cur_nib = act_data[idx*4 +: 4];
  assign cur_dp  = act_dp[idx];
  assign anode   = ~(NUM_DIGITS'(1) << idx);

  seg_decode u_decode (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // hi_zero[i]: nibble i and every nibble above it are zero.
  always_comb begin
    hi_zero = '0;
    hi_zero[NUM_DIGITS-1] = (act_data[DW-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      hi_zero[i] = hi_zero[i+1] && (act_data[i*4 +: 4] == 4'd0);
    end
  end

  assign duty_prod = (PW'(act_bright) + PW'(1)) * PW'(REFRESH_DIV);
  assign on_time   = duty_prod >> BRIGHT_BITS;
  assign lit       = act_valid && (cnt != '0) && (PW'(cnt) < on_time);
  assign blanked   = act_blz && (idx != '0) && hi_zero[idx];

  always_comb begin
    sel_d = '1;
    out_d = SEG_OFF;
    if (lit) begin
      if (!blanked) begin
        sel_d = anode;
        out_d = {~cur_dp, cur_seg};
      end else if (cur_dp) begin
        sel_d = anode;
        out_d = 8'h7F;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      LEDSEL      <= '1;
      LEDOUT      <= SEG_OFF;
      frame_start <= 1'b0;
    end else begin
      LEDSEL      <= sel_d;
      LEDOUT      <= out_d;
      frame_start <= (cnt == '0) && (idx == '0);
    end
  end

endmodule
